// File: rtl/shift_seq_ctrl_if.sv
// Requester-side handshake bundle for shift_seq_ctrl: start/abort/TX word in,
// ready/busy status and the captured RX word out.
interface shift_seq_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic         abort;
    logic [N-1:0] data;
    logic         ready;
    logic         busy;
    logic [N-1:0] rx_data;
    logic         rx_valid;

    modport master (
        output start, abort, data,
        input  ready, busy, rx_data, rx_valid
    );

    modport slave (
        input  start, abort, data,
        output ready, busy, rx_data, rx_valid
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving an external shift register for one full-duplex LSB-first
// serial transfer per request. Define SHIFT_DIV_EN to prescale shifts by DIV.
module shift_seq_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 4,
    parameter int DIV   = 4
) (
    input  logic             clock,
    input  logic             reset,
    shift_seq_ctrl_if.slave  req,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             sr_enable,
    output logic             sr_reset,
    output logic             sr_load,
    output logic             sr_bit_in,
    output logic [N-1:0]     sr_data,
    input  logic [N-1:0]     sr_q
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     tx_latch;
    logic [CNT_W-1:0] bit_cnt;
    logic             tick;
    logic             last_bit;
    logic             cancel;

    if (N < 1 || (2 ** CNT_W) < N || DIV < 1) begin : g_bad_param
        $error("shift_seq_ctrl: illegal N/CNT_W/DIV combination");
    end

`ifdef SHIFT_DIV_EN
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PS_W-1:0] prescale;

    // Held at zero outside SHIFT, so every SHIFT entry starts a fresh bit period.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prescale <= '0;
        end else if (state != SHIFT || req.abort || tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    always_comb begin
        tick = (prescale == PS_W'(DIV - 1));
    end
`else
    always_comb begin
        tick = 1'b1;
    end
`endif

    always_comb begin
        last_bit = (bit_cnt == CNT_W'(N - 1));
        cancel   = (state != IDLE) && req.abort;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort also blocks a simultaneous start in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req.start && !req.abort) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = req.abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (req.abort) begin
                    state_nxt = IDLE;
                end else if (tick && last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_latch     <= '0;
            bit_cnt      <= '0;
            req.rx_data  <= '0;
            req.rx_valid <= 1'b0;
        end else begin
            req.rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.start && !req.abort) begin
                        tx_latch <= req.data;
                    end
                end
                LOAD: begin
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (req.abort) begin
                        bit_cnt <= '0;
                    end else if (tick) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!req.abort) begin
                        req.rx_data  <= sr_q;
                        req.rx_valid <= 1'b1;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Reset and abort both clear the shift register on the same edge they act.
    always_comb begin
        req.ready = (state == IDLE);
        req.busy  = (state != IDLE);
        ser_out   = 1'b1;
        sr_enable = 1'b0;
        sr_reset  = 1'b0;
        sr_load   = 1'b0;
        sr_bit_in = ser_in;
        sr_data   = tx_latch;
        case (state)
            LOAD: begin
                sr_enable = 1'b1;
                sr_load   = 1'b1;
            end
            SHIFT: begin
                sr_enable = tick;
                ser_out   = sr_q[0];
            end
            default: begin
                sr_enable = 1'b0;
            end
        endcase
        if (!reset || cancel) begin
            sr_enable = 1'b1;
            sr_reset  = 1'b1;
            sr_load   = 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed plus randomized bench for shift_seq_ctrl with a behavioural shift
// register attached; expectations come from per-cycle transfer arithmetic.
module tb_shift_seq_ctrl;

    localparam int N = 8;
`ifdef SHIFT_DIV_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif
    localparam int LAST = N * D + 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         ser_in;
    logic         ser_out;
    logic         sr_enable;
    logic         sr_reset;
    logic         sr_load;
    logic         sr_bit_in;
    logic [N-1:0] sr_data;
    logic [N-1:0] sr_q;
    logic [N-1:0] exp_rx;
    int           errors = 0;
    int           checks = 0;

    shift_seq_ctrl_if #(.N(N)) bus ();

    shift_seq_ctrl #(
        .N     (N),
        .CNT_W (4),
        .DIV   (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (bus),
        .ser_in    (ser_in),
        .ser_out   (ser_out),
        .sr_enable (sr_enable),
        .sr_reset  (sr_reset),
        .sr_load   (sr_load),
        .sr_bit_in (sr_bit_in),
        .sr_data   (sr_data),
        .sr_q      (sr_q)
    );

    always #5 clock = ~clock;

    // Behavioural model of the attached shift register.
    always @(posedge clock) begin
        if (sr_reset) begin
            sr_q <= '0;
        end else if (sr_enable) begin
            sr_q <= sr_load ? sr_data : {sr_bit_in, sr_q[N-1:1]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One transfer, cycle k counted from the accepting edge (k=1 is LOAD).
    task automatic xfer(input logic [N-1:0] tx, input logic [N-1:0] rxw,
                        input int abort_k, input int rst_k, input int pulse_k,
                        input bit keep, input logic [N-1:0] next_tx);
        int en_cnt;
        int s;
        en_cnt = 0;
        bus.start = 1'b1;
        bus.data  = tx;
        bus.abort = 1'b0;
        #1;
        chk("accept_ready", bus.ready, 1);
        @(posedge clock);
        #1;
        for (int k = 1; k <= LAST; k++) begin
            s = k - 2;
            bus.start = keep || (k == pulse_k);
            if (keep && k == 1) bus.data = next_tx;
            else if (!keep) bus.data = N'($urandom);
            ser_in    = (s >= 0 && s < N * D) ? rxw[s / D] : 1'($urandom);
            bus.abort = (k == abort_k);
            reset     = (k != rst_k);
            #1;
            chk("bit_in_pass", sr_bit_in, ser_in);
            if (k == abort_k || k == rst_k) begin
                chk("cancel_sr_reset", sr_reset, 1);
                chk("cancel_sr_enable", sr_enable, 1);
                chk("cancel_sr_load", sr_load, 0);
                @(posedge clock);
                #1;
                bus.abort = 1'b0;
                reset     = 1'b1;
                bus.start = 1'b0;
                if (k == rst_k) exp_rx = '0;
                chk("cancel_ready", bus.ready, 1);
                chk("cancel_rx_valid", bus.rx_valid, 0);
                chk("cancel_rx_data", bus.rx_data, exp_rx);
                chk("cancel_sr_q", sr_q, 0);
                return;
            end
            if (k == 1) begin
                chk("load_sr_load", sr_load, 1);
                chk("load_sr_enable", sr_enable, 1);
                chk("load_sr_data", sr_data, tx);
                chk("load_busy", bus.busy, 1);
                chk("load_ready", bus.ready, 0);
            end else if (s < N * D) begin
                chk("shift_ser_out", ser_out, tx[s / D]);
                chk("shift_sr_enable", sr_enable, (s % D) == D - 1);
                chk("shift_sr_load", sr_load, 0);
                chk("shift_sr_reset", sr_reset, 0);
                chk("shift_ready", bus.ready, 0);
                chk("shift_busy", bus.busy, 1);
                if (sr_enable) en_cnt++;
            end else if (k == N * D + 2) begin
                chk("shift_count", en_cnt, N);
                chk("done_sr_enable", sr_enable, 0);
                chk("done_busy", bus.busy, 1);
                chk("done_rx_valid", bus.rx_valid, 0);
            end else if (k == N * D + 3) begin
                chk("valid_strobe", bus.rx_valid, 1);
                chk("valid_rx_data", bus.rx_data, rxw);
                chk("valid_ready", bus.ready, 1);
                chk("valid_busy", bus.busy, 0);
                exp_rx = rxw;
                if (keep) return;
            end else begin
                chk("post_rx_valid", bus.rx_valid, 0);
                chk("post_rx_data", bus.rx_data, exp_rx);
                chk("post_ready", bus.ready, 1);
                chk("post_ser_out", ser_out, 1);
            end
            if (k != LAST) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    initial begin
        logic [N-1:0] tx;
        logic [N-1:0] rxw;
        int           mode;
        int           pick;

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.data  = '0;
        ser_in    = 1'b0;
        exp_rx    = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_sr_reset", sr_reset, 1);
        chk("rst_sr_enable", sr_enable, 1);
        chk("rst_ser_out", ser_out, 1);
        chk("rst_sr_q", sr_q, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_sr_reset", sr_reset, 0);
        chk("idle_sr_enable", sr_enable, 0);
        chk("idle_sr_data", sr_data, 0);

        xfer(8'hA5, 8'h3C, 0, 0, 0, 1'b0, 8'h00);
        // Back-to-back: start held, second LOAD right after the rx_valid cycle.
        xfer(8'h01, 8'($urandom), 0, 0, 0, 1'b1, 8'h80);
        xfer(8'h80, 8'($urandom), 0, 0, 0, 1'b0, 8'h00);
        xfer(8'h5A, 8'($urandom), 0, 0, 5, 1'b0, 8'h00);
        xfer(8'hC3, 8'($urandom), 4, 0, 0, 1'b0, 8'h00);
        xfer(8'h96, 8'($urandom), 0, 5, 0, 1'b0, 8'h00);
        chk("post_reset_sr_data", sr_data, 0);
        xfer(8'hFF, 8'($urandom), 0, 0, 0, 1'b0, 8'h00);

        for (int i = 0; i < 12; i++) begin
            tx   = N'($urandom);
            rxw  = N'($urandom);
            mode = int'($urandom_range(0, 3));
            case (mode)
                1: begin
                    pick = int'($urandom_range(1, N * D + 2));
                    xfer(tx, rxw, pick, 0, 0, 1'b0, 8'h00);
                end
                2: begin
                    pick = int'($urandom_range(2, N * D + 2));
                    xfer(tx, rxw, 0, 0, pick, 1'b0, 8'h00);
                end
                3: begin
                    pick = int'($urandom_range(1, N * D + 2));
                    xfer(tx, rxw, 0, pick, 0, 1'b0, 8'h00);
                end
                default: xfer(tx, rxw, 0, 0, 0, 1'b0, 8'h00);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer for the team's parameterised shift register (sync active-high reset, enable, load, bit_in; shifts right with bit_in entering the MSB).
- Performs one full-duplex serial transfer per request: parallel-loads the TX word, shifts exactly N times while feeding ser_in into the MSB, then returns the captured RX word.
- Sits between a parallel requester (start/ready) and a serial pin pair.

Parameters:
N, 8, word width; must match the shift register's n.
CNT_W, 4, bit-counter width; 2**CNT_W must be >= N.
DIV, 4, shift prescale in cycles per bit; used only when SHIFT_DIV_EN is defined; must be >= 1.

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  transfer request; accepted only when ready=1.
abort  in  1  synchronous cancel of a transfer in progress.
data  in  N  TX word, sampled on the accepting edge.
ready  out  1  high only in IDLE.
busy  out  1  high in LOAD, SHIFT and DONE.
ser_in  in  1  serial receive bit.
ser_out  out  1  serial transmit bit.
rx_data  out  N  last completed RX word.
rx_valid  out  1  one-cycle completion strobe.
sr_enable  out  1  to the shift register's enable.
sr_reset  out  1  to the shift register's reset (active-high).
sr_load  out  1  to the shift register's load.
sr_bit_in  out  1  to the shift register's bit_in.
sr_data  out  N  to the shift register's data.
sr_q  in  N  from the shift register's q.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, bit_cnt=0, tx latch=0, rx_data=0, rx_valid=0.
  - While reset=0, sr_enable=1 and sr_reset=1 combinationally, so the shift register clears on the same edge.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - ready=1, busy=0, ser_out=1 (idle-high line), sr_enable=0.
  - start=1 at an edge: latch data, go to LOAD.
- LOAD (1 cycle):
  - sr_enable=1, sr_load=1, sr_data=latched word.
  - Go to SHIFT with bit_cnt=0.
- SHIFT:
  - Each shift cycle: sr_enable=1, sr_load=0, sr_bit_in=ser_in (combinational pass-through), ser_out=sr_q[0]. Transfer is LSB first.
  - bit_cnt increments per shift.
  - On the shift with bit_cnt==N-1, go to DONE. Exactly N shifts occur.
- DONE (1 cycle):
  - sr_enable=0.
  - At the exit edge: rx_data<=sr_q, rx_valid<=1, go to IDLE.
- rx_valid:
  - High for exactly the one cycle after DONE; that cycle is IDLE with ready=1.
  - rx_data holds until the next DONE or reset.
- Latency (no prescale): start accepted at edge E0; LOAD = cycle 1; SHIFT = cycles 2..N+1; DONE = cycle N+2; rx_valid in cycle N+3.
- Back-to-back: if start=1 in the rx_valid cycle, it is accepted; LOAD follows immediately.
- start while busy=1 is ignored and not queued.
- abort=1 in LOAD, SHIFT or DONE:
  - During that cycle, sr_enable=1 and sr_reset=1 combinationally (overriding load/shift).
  - Next state IDLE; rx_valid stays 0 and rx_data is unchanged.
  - abort in IDLE has no effect, and abort wins over a simultaneous start.
- Reset priority: reset has priority over abort and start.
- Reset mid-transfer: next cycle IDLE, rx_valid=0, rx_data=0.
- sr_reset=0 in every case not listed above.
- sr_data always shows the latched word.

Optional Feature:
- Macro: SHIFT_DIV_EN.
- Defined:
  - SHIFT uses a prescale counter 0..DIV-1, reset to 0 on entering SHIFT.
  - sr_enable=1 and bit_cnt advances only when prescale==DIV-1, so each bit is held on ser_out for DIV cycles and SHIFT lasts N*DIV cycles.
  - abort and reset also clear the prescaler.
- Undefined:
  - No prescaler logic; one shift per cycle as described above.

Test Plan:
- N=8, data=0xA5, ser_in drives 0x3C LSB first during SHIFT -> ser_out = 1,0,1,0,0,1,0,1 in cycles 2..9; rx_data=0x3C with rx_valid=1 in cycle 11 only; exactly 8 sr_enable cycles in SHIFT.
- start held high across two transfers (data 0x01 then 0x80) -> second LOAD in the rx_valid cycle plus 1; no idle gap beyond that single IDLE cycle; both RX words captured correctly.
- start pulsed during SHIFT (cycle 5) -> ignored; exactly one rx_valid; ready stays 0 until the transfer completes.
- abort=1 in the 3rd SHIFT cycle -> sr_reset=1 and sr_enable=1 in that cycle, IDLE next cycle, no rx_valid, rx_data keeps its prior value, sr_q=0x00 afterward.
- reset=0 for 1 cycle during SHIFT -> IDLE next cycle, rx_data=0x00, rx_valid=0, shift register cleared; a subsequent transfer of 0xFF completes normally.
- SHIFT_DIV_EN with DIV=4, data=0x5A -> each ser_out bit stable for 4 cycles; SHIFT lasts 32 cycles; rx_valid in cycle 35.
